// File: rtl/dispense_sequencer.sv
// Drink dispense sequencer: walks the selected recipe one ingredient at a time,
// holding each valve open for its duration in prescaled ticks.
module dispense_sequencer #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk_fpga,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] sel,
    input  logic       abort,
    output logic       led_agua,
    output logic       led_cafe,
    output logic       led_leche,
    output logic       led_chocolate,
    output logic       led_azucar,
    output logic [2:0] paso,
    output logic       busy,
    output logic       done,
    output logic       fallo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DISPENSE,
        S_DONE
    } state_t;

    localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

    state_t      state;
    state_t      state_d;
    logic [2:0]  sel_q;
    logic [2:0]  ing;
    logic [7:0]  presc;
    logic [10:0] dur_cnt;
    logic        fail_q;

    logic [2:0]  cur_dur;
    logic [3:0]  first_ing;
    logic [3:0]  next_ing;
    logic        sel_valid;
    logic        tick;
    logic        seg_end;

    logic [4:0]  leds_d;
    logic [2:0]  paso_d;
    logic        busy_d;
    logic        done_d;
    logic        fallo_d;
    logic [4:0]  leds_q;

    // Durations in ticks, indexed 0 agua .. 4 azucar.
    function automatic logic [2:0] dur_of(input logic [2:0] s,
                                          input logic [2:0] i);
        logic [14:0] row;
        logic [2:0]  d;
        case (s)
            3'b000:  row = {3'd1, 3'd0, 3'd0, 3'd2, 3'd4};
            3'b001:  row = {3'd1, 3'd0, 3'd2, 3'd2, 3'd3};
            3'b010:  row = {3'd1, 3'd3, 3'd3, 3'd0, 3'd0};
            3'b011:  row = {3'd0, 3'd1, 3'd3, 3'd2, 3'd2};
            3'b100:  row = {3'd0, 3'd0, 3'd0, 3'd0, 3'd5};
            default: row = '0;
        endcase
        case (i)
            3'd0:    d = row[2:0];
            3'd1:    d = row[5:3];
            3'd2:    d = row[8:6];
            3'd3:    d = row[11:9];
            3'd4:    d = row[14:12];
            default: d = 3'd0;
        endcase
        return d;
    endfunction

    // Lowest ingredient index >= lo with nonzero duration; MSB flags a hit.
    function automatic logic [3:0] find_ing(input logic [2:0] s,
                                            input int lo);
        logic [3:0] r;
        r = '0;
        for (int k = 4; k >= 0; k--) begin
            if (k >= lo && dur_of(s, 3'(k)) != 3'd0) begin
                r = {1'b1, 3'(k)};
            end
        end
        return r;
    endfunction

    assign sel_valid = (sel_q <= 3'd4);
    assign cur_dur   = dur_of(sel_q, ing);
    assign first_ing = find_ing(sel_q, 0);
    assign next_ing  = find_ing(sel_q, int'(ing) + 1);
    assign tick      = (presc == PRESC_MAX);
    assign seg_end   = tick && (dur_cnt == 11'(cur_dur) - 11'd1);

    always_ff @(posedge clk_fpga or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (abort || !sel_valid) state_d = S_IDLE;
                else if (first_ing[3])   state_d = S_DISPENSE;
                else                     state_d = S_DONE;
            end
            S_DISPENSE: begin
                if (abort)                        state_d = S_IDLE;
                else if (seg_end && !next_ing[3]) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded one edge behind the state, except abort which
    // must blank the valves on the very edge it is seen.
    always_comb begin
        leds_d  = '0;
        paso_d  = '0;
        busy_d  = (state != S_IDLE);
        done_d  = (state == S_DONE);
        fallo_d = fail_q;
        if (state == S_DISPENSE && !abort) begin
            leds_d = 5'd1 << ing;
            paso_d = ing;
        end
        if (abort && (state == S_LOAD || state == S_DISPENSE)) begin
            fallo_d = 1'b1;
        end
    end

    always_ff @(posedge clk_fpga or posedge rst) begin
        if (rst) begin
            sel_q   <= '0;
            ing     <= '0;
            presc   <= '0;
            dur_cnt <= '0;
            fail_q  <= 1'b0;
        end else begin
            fail_q <= (state == S_LOAD) && !abort && !sel_valid;
            unique case (state)
                S_IDLE: begin
                    if (start) sel_q <= sel;
                end
                S_LOAD: begin
                    ing     <= first_ing[2:0];
                    presc   <= '0;
                    dur_cnt <= '0;
                end
                S_DISPENSE: begin
                    if (tick) begin
                        presc <= '0;
                        if (seg_end) begin
                            dur_cnt <= '0;
                            if (next_ing[3]) ing <= next_ing[2:0];
                        end else begin
                            dur_cnt <= dur_cnt + 11'd1;
                        end
                    end else begin
                        presc <= presc + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_fpga or posedge rst) begin
        if (rst) begin
            leds_q <= '0;
            paso   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            fallo  <= 1'b0;
        end else begin
            leds_q <= leds_d;
            paso   <= paso_d;
            busy   <= busy_d;
            done   <= done_d;
            fallo  <= fallo_d;
        end
    end

    assign led_agua      = leds_q[0];
    assign led_cafe      = leds_q[1];
    assign led_leche     = leds_q[2];
    assign led_chocolate = leds_q[3];
    assign led_azucar    = leds_q[4];

endmodule
